// File: rtl/ctrl_pkg.sv
// Shared encodings and counter widths for the game sequencing controller.
// Direction defaults match the original top-level Pac-Man build.
package ctrl_pkg;

  localparam int STATE_W = 3;
  localparam int DIR_W   = 2;
  localparam int TIMER_W = 8;
  localparam int AGE_W   = 6;
  localparam int DIV_W   = 4;
  localparam int ANIM_W  = 3;
  localparam int LIVES_W = 3;
  localparam int LEVEL_W = 8;

  localparam logic [STATE_W-1:0] ST_IDLE     = 3'd0;
  localparam logic [STATE_W-1:0] ST_READY    = 3'd1;
  localparam logic [STATE_W-1:0] ST_PLAY     = 3'd2;
  localparam logic [STATE_W-1:0] ST_DYING    = 3'd3;
  localparam logic [STATE_W-1:0] ST_CLEAR    = 3'd4;
  localparam logic [STATE_W-1:0] ST_GAMEOVER = 3'd5;

  localparam logic [DIR_W-1:0] DIR_UP    = 2'd0;
  localparam logic [DIR_W-1:0] DIR_RIGHT = 2'd1;
  localparam logic [DIR_W-1:0] DIR_LEFT  = 2'd2;
  localparam logic [DIR_W-1:0] DIR_DOWN  = 2'd3;

  function automatic logic [LEVEL_W-1:0] sat_inc_level(input logic [LEVEL_W-1:0] v);
    return (v == {LEVEL_W{1'b1}}) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/game_ctrl_if.sv
// Button/VGA/map-facing signal bundle of game_ctrl; master drives the inputs,
// slave is the controller side.
interface game_ctrl_if;
  import ctrl_pkg::*;

  logic [3:0]         btn;
  logic               start;
  logic               VS;
  logic               turn_ok;
  logic               fwd_ok;
  logic               pac_hit;
  logic               dots_clear;
  logic [STATE_W-1:0] state;
  logic [DIR_W-1:0]   cur_dir;
  logic [DIR_W-1:0]   req_dir;
  logic               req_valid;
  logic               frame_tick;
  logic               step;
  logic [ANIM_W-1:0]  anim_frame;
  logic [LIVES_W-1:0] lives;
  logic [LEVEL_W-1:0] level;

  modport master (
    output btn, start, VS, turn_ok, fwd_ok, pac_hit, dots_clear,
    input  state, cur_dir, req_dir, req_valid, frame_tick, step,
           anim_frame, lives, level
  );

  modport slave (
    input  btn, start, VS, turn_ok, fwd_ok, pac_hit, dots_clear,
    output state, cur_dir, req_dir, req_valid, frame_tick, step,
           anim_frame, lives, level
  );

endinterface

// File: rtl/game_ctrl_turn_buffer.sv
// Turn-request buffer: priority-encodes buttons into a pending direction that
// commits on an open tile or ages out after TURN_HOLD play frames.
module turn_buffer
  import ctrl_pkg::*;
#(
  parameter logic [DIR_W-1:0] UP        = DIR_UP,
  parameter logic [DIR_W-1:0] RIGHT     = DIR_RIGHT,
  parameter logic [DIR_W-1:0] LEFT      = DIR_LEFT,
  parameter logic [DIR_W-1:0] DOWN      = DIR_DOWN,
  parameter int               TURN_HOLD = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [3:0]       btn,
  input  logic             accept,
  input  logic             play_tick,
  input  logic             turn_ok,
  input  logic             clear,
  output logic [DIR_W-1:0] cur_dir,
  output logic [DIR_W-1:0] req_dir,
  output logic             req_valid
);

  localparam logic [AGE_W-1:0] AGE_LAST = AGE_W'(TURN_HOLD - 1);

  logic [AGE_W-1:0] age;
  logic [DIR_W-1:0] press_dir;
  logic             press;

  // btn is {down, right, left, up}; priority up > left > right > down.
  always_comb begin
    press_dir = DOWN;
    if (btn[0])      press_dir = UP;
    else if (btn[1]) press_dir = LEFT;
    else if (btn[2]) press_dir = RIGHT;
  end

  assign press = accept && (btn != 4'b0000);

  always_ff @(posedge clk) begin
    if (rst) begin
      cur_dir   <= LEFT;
      req_dir   <= LEFT;
      req_valid <= 1'b0;
      age       <= '0;
    end else if (clear) begin
      cur_dir   <= LEFT;
      req_valid <= 1'b0;
      age       <= '0;
    end else if (press) begin
      // A fresh press beats any commit or ageing in the same cycle.
      req_dir   <= press_dir;
      req_valid <= 1'b1;
      age       <= '0;
    end else if (play_tick && req_valid) begin
      if (turn_ok) begin
        cur_dir   <= req_dir;
        req_valid <= 1'b0;
      end else if (age == AGE_LAST) begin
        req_valid <= 1'b0;
      end else begin
        age <= age + 1'b1;
      end
    end
  end

endmodule

// File: rtl/game_ctrl.sv
// Game sequencing: state FSM, VS-derived frame tick, movement-step divider and
// sprite animation counter; turn requests live in turn_buffer.
module game_ctrl
  import ctrl_pkg::*;
#(
  parameter logic [DIR_W-1:0] UP           = DIR_UP,
  parameter logic [DIR_W-1:0] RIGHT        = DIR_RIGHT,
  parameter logic [DIR_W-1:0] LEFT         = DIR_LEFT,
  parameter logic [DIR_W-1:0] DOWN         = DIR_DOWN,
  parameter int               LIVES        = 3,
  parameter int               FRAME_DIV    = 1,
  parameter int               ANIM_FRAMES  = 3,
  parameter int               TURN_HOLD    = 8,
  parameter int               READY_FRAMES = 120,
  parameter int               DEATH_FRAMES = 90,
  parameter int               CLEAR_FRAMES = 120
) (
  input logic        CLK,
  input logic        RST,
  game_ctrl_if.slave bus
);

  localparam logic [TIMER_W-1:0] READY_LAST = TIMER_W'(READY_FRAMES - 1);
  localparam logic [TIMER_W-1:0] DEATH_LAST = TIMER_W'(DEATH_FRAMES - 1);
  localparam logic [TIMER_W-1:0] CLEAR_LAST = TIMER_W'(CLEAR_FRAMES - 1);
  localparam logic [DIV_W-1:0]   DIV_LAST   = DIV_W'(FRAME_DIV - 1);
  localparam logic [ANIM_W-1:0]  ANIM_LAST  = ANIM_W'(ANIM_FRAMES - 1);
  localparam logic [LIVES_W-1:0] LIVES_INIT = LIVES_W'(LIVES);

  logic               vs_q;
  logic               frame_tick_q;
  logic [STATE_W-1:0] state_q, state_d;
  logic [TIMER_W-1:0] timer_q, timer_d;
  logic [LIVES_W-1:0] lives_q, lives_d;
  logic [LEVEL_W-1:0] level_q, level_d;
  logic [DIV_W-1:0]   div_q;
  logic               step_pend_q;
  logic [ANIM_W-1:0]  anim_q;
  logic               enter_ready;
  logic               play_tick;
  logic               accept;
  logic               step_now;

  assign play_tick = frame_tick_q && (state_q == ST_PLAY);
  assign accept    = (state_q == ST_READY) || (state_q == ST_PLAY);

  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    lives_d = lives_q;
    level_d = level_q;
    if (frame_tick_q) begin
      case (state_q)
        ST_IDLE: begin
          if (bus.start) state_d = ST_READY;
        end
        ST_READY: begin
          if (timer_q == READY_LAST) state_d = ST_PLAY;
          else timer_d = timer_q + 1'b1;
        end
        ST_PLAY: begin
          if (bus.pac_hit)         state_d = ST_DYING;
          else if (bus.dots_clear) state_d = ST_CLEAR;
        end
        ST_DYING: begin
          if (timer_q == DEATH_LAST) begin
            lives_d = lives_q - 1'b1;
            state_d = (lives_q == 3'd1) ? ST_GAMEOVER : ST_READY;
          end else begin
            timer_d = timer_q + 1'b1;
          end
        end
        ST_CLEAR: begin
          if (timer_q == CLEAR_LAST) begin
            level_d = sat_inc_level(level_q);
            state_d = ST_READY;
          end else begin
            timer_d = timer_q + 1'b1;
          end
        end
        ST_GAMEOVER: begin
          if (bus.start) begin
            lives_d = LIVES_INIT;
            level_d = '0;
            state_d = ST_READY;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
    // Each state's timer starts from zero on entry.
    if (state_d != state_q) timer_d = '0;
  end

  assign enter_ready = (state_d == ST_READY) && (state_q != ST_READY);

  always_ff @(posedge CLK) begin
    if (RST) begin
      vs_q         <= 1'b0;
      frame_tick_q <= 1'b0;
      state_q      <= ST_IDLE;
      timer_q      <= '0;
      lives_q      <= LIVES_INIT;
      level_q      <= '0;
    end else begin
      vs_q         <= bus.VS;
      frame_tick_q <= vs_q && !bus.VS;
      state_q      <= state_d;
      timer_q      <= timer_d;
      lives_q      <= lives_d;
      level_q      <= level_d;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      div_q       <= '0;
      step_pend_q <= 1'b0;
    end else begin
      step_pend_q <= play_tick && (div_q == DIV_LAST);
      if (play_tick) div_q <= (div_q == DIV_LAST) ? '0 : div_q + 1'b1;
    end
  end

  // fwd_ok is taken live so the map can judge the freshly committed cur_dir.
  assign step_now = step_pend_q && (state_q == ST_PLAY) && bus.fwd_ok;

  always_ff @(posedge CLK) begin
    if (RST) begin
      anim_q <= '0;
    end else if (enter_ready) begin
      anim_q <= '0;
    end else if (step_now) begin
      anim_q <= (anim_q == ANIM_LAST) ? '0 : anim_q + 1'b1;
    end
  end

  turn_buffer #(
    .UP        (UP),
    .RIGHT     (RIGHT),
    .LEFT      (LEFT),
    .DOWN      (DOWN),
    .TURN_HOLD (TURN_HOLD)
  ) u_turn_buffer (
    .clk       (CLK),
    .rst       (RST),
    .btn       (bus.btn),
    .accept    (accept),
    .play_tick (play_tick),
    .turn_ok   (bus.turn_ok),
    .clear     (enter_ready),
    .cur_dir   (bus.cur_dir),
    .req_dir   (bus.req_dir),
    .req_valid (bus.req_valid)
  );

  assign bus.state      = state_q;
  assign bus.frame_tick = frame_tick_q;
  assign bus.step       = step_now;
  assign bus.anim_frame = anim_q;
  assign bus.lives      = lives_q;
  assign bus.level      = level_q;

endmodule

// File: tb/tb_game_ctrl.sv
// Randomized scoreboard bench for game_ctrl against a frame-level reference model.
module tb_game_ctrl;

  localparam int P_LIVES = 3;
  localparam int P_FDIV  = 2;
  localparam int P_ANIM  = 3;
  localparam int P_HOLD  = 8;
  localparam int P_READY = 6;
  localparam int P_DEATH = 5;
  localparam int P_CLEAR = 3;

  localparam int S_IDLE = 0, S_READY = 1, S_PLAY = 2, S_DYING = 3, S_CLEAR = 4, S_OVER = 5;
  localparam int D_UP = 0, D_RIGHT = 1, D_LEFT = 2, D_DOWN = 3;
  localparam int MODE_RANDOM = 0, MODE_DEATH = 1, MODE_CLEAR = 2, MODE_QUIET = 3;

  typedef struct {
    int state; int cur; int req; int reqv; int ft;
    int step; int anim; int lives; int level;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  game_ctrl_if bus ();

  game_ctrl #(
    .UP(2'd0), .RIGHT(2'd1), .LEFT(2'd2), .DOWN(2'd3),
    .LIVES(P_LIVES), .FRAME_DIV(P_FDIV), .ANIM_FRAMES(P_ANIM), .TURN_HOLD(P_HOLD),
    .READY_FRAMES(P_READY), .DEATH_FRAMES(P_DEATH), .CLEAR_FRAMES(P_CLEAR)
  ) dut (
    .CLK (clk),
    .RST (rst),
    .bus (bus)
  );

  exp_t exp_q[$];
  int checks = 0;
  int failures = 0;

  int m_state, m_ticks, m_cur, m_req, m_reqv, m_age, m_ft, m_vs_prev;
  int m_play_ticks, m_step_pend, m_step, m_anim, m_lives, m_level;

  int mode = MODE_RANDOM;
  int rst_pulse = 0;
  int vs_cnt = 0;
  int vs_period = 4;

  function automatic int prio_dir(input logic [3:0] b);
    if (b[0]) return D_UP;
    if (b[1]) return D_LEFT;
    if (b[2]) return D_RIGHT;
    return D_DOWN;
  endfunction

  // Reference: everything advances on frame ticks in terms of whole-state rules.
  task automatic model_edge(input bit r, input logic [3:0] b, input bit st, input bit vs,
                            input bit tok, input bit ph, input bit dc);
    int old;
    bit tick, go_ready;
    if (r) begin
      m_state = S_IDLE; m_ticks = 0; m_cur = D_LEFT; m_req = D_LEFT; m_reqv = 0;
      m_age = 0; m_ft = 0; m_vs_prev = 0; m_play_ticks = 0; m_step_pend = 0;
      m_step = 0; m_anim = 0; m_lives = P_LIVES; m_level = 0;
      return;
    end
    old = m_state;
    tick = (m_ft != 0);
    go_ready = 0;
    if (m_step != 0) m_anim = (m_anim + 1) % P_ANIM;
    if ((old == S_READY || old == S_PLAY) && b != 4'b0000) begin
      m_req = prio_dir(b); m_reqv = 1; m_age = 0;
    end else if (old == S_PLAY && tick && m_reqv != 0) begin
      if (tok) begin m_cur = m_req; m_reqv = 0; end
      else if (m_age == P_HOLD - 1) m_reqv = 0;
      else m_age++;
    end
    m_step_pend = 0;
    if (old == S_PLAY && tick) begin
      m_play_ticks++;
      m_step_pend = (m_play_ticks % P_FDIV) == 0;
    end
    if (tick) begin
      if (old == S_READY || old == S_DYING || old == S_CLEAR) m_ticks++;
      case (old)
        S_IDLE:  if (st) go_ready = 1;
        S_READY: if (m_ticks == P_READY) m_state = S_PLAY;
        S_PLAY:  if (ph) m_state = S_DYING; else if (dc) m_state = S_CLEAR;
        S_DYING: if (m_ticks == P_DEATH) begin
          m_lives--;
          if (m_lives == 0) m_state = S_OVER; else go_ready = 1;
        end
        S_CLEAR: if (m_ticks == P_CLEAR) begin
          if (m_level < 255) m_level++;
          go_ready = 1;
        end
        S_OVER: if (st) begin m_lives = P_LIVES; m_level = 0; go_ready = 1; end
        default: ;
      endcase
    end
    if (go_ready) begin
      m_state = S_READY; m_cur = D_LEFT; m_reqv = 0; m_anim = 0;
    end
    if (m_state != old) m_ticks = 0;
    m_ft = (m_vs_prev != 0 && !vs) ? 1 : 0;
    m_vs_prev = vs;
  endtask

  task automatic gen_inputs();
    rst = (rst_pulse > 0);
    if (rst_pulse > 0) rst_pulse--;
    vs_cnt++;
    if (vs_cnt >= vs_period) begin
      vs_cnt = 0;
      vs_period = $urandom_range(3, 5);
    end
    bus.VS = (vs_cnt == 0) ? 1'b0 : 1'b1;
    bus.fwd_ok  = ($urandom_range(0, 4) != 0);
    bus.turn_ok = ($urandom_range(0, 3) == 0);
    bus.btn = ($urandom_range(0, 59) == 0) ? 4'($urandom_range(1, 15)) : 4'b0000;
    case (mode)
      MODE_RANDOM: begin
        bus.start      = ($urandom_range(0, 7) == 0);
        bus.pac_hit    = ($urandom_range(0, 60) == 0);
        bus.dots_clear = ($urandom_range(0, 80) == 0);
      end
      MODE_DEATH: begin
        bus.start = (bus.state == 3'(S_IDLE));
        bus.pac_hit = 1'b1;
        bus.dots_clear = ($urandom_range(0, 1) == 0);
      end
      MODE_CLEAR: begin
        bus.start = 1'b1; bus.pac_hit = 1'b0; bus.dots_clear = 1'b1;
      end
      default: begin
        bus.start = 1'b0; bus.pac_hit = 1'b0; bus.dots_clear = 1'b0; bus.btn = 4'b0000;
      end
    endcase
  endtask

  task automatic cycle();
    exp_t e;
    @(posedge clk);
    model_edge(rst, bus.btn, bus.start, bus.VS, bus.turn_ok, bus.pac_hit, bus.dots_clear);
    #1;
    gen_inputs();
    e.state = m_state; e.cur = m_cur; e.req = m_req; e.reqv = m_reqv; e.ft = m_ft;
    e.step = (m_step_pend != 0 && m_state == S_PLAY && bus.fwd_ok) ? 1 : 0;
    e.anim = m_anim; e.lives = m_lives; e.level = m_level;
    m_step = e.step;
    exp_q.push_back(e);
  endtask

  task automatic run_until_state(input int s, input int budget, input string name);
    int n;
    n = 0;
    while (int'(bus.state) != s && n < budget) begin
      cycle();
      n++;
    end
    checks++;
    if (int'(bus.state) != s) begin
      failures++;
      $display("FAIL %s: state=%0d after %0d cycles, required %0d", name, bus.state, n, s);
    end
  endtask

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      failures++;
      if (failures <= 25)
        $display("FAIL %s: got %0d required %0d at %0t", name, act, req, $time);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("state",      int'(bus.state),      e.state);
      chk("cur_dir",    int'(bus.cur_dir),    e.cur);
      chk("req_dir",    int'(bus.req_dir),    e.req);
      chk("req_valid",  int'(bus.req_valid),  e.reqv);
      chk("frame_tick", int'(bus.frame_tick), e.ft);
      chk("step",       int'(bus.step),       e.step);
      chk("anim_frame", int'(bus.anim_frame), e.anim);
      chk("lives",      int'(bus.lives),      e.lives);
      chk("level",      int'(bus.level),      e.level);
    end
  end

  initial begin
    int n;
    rst = 1'b1;
    rst_pulse = 3;
    bus.btn = 4'b0000; bus.start = 1'b0; bus.VS = 1'b1; bus.turn_ok = 1'b0;
    bus.fwd_ok = 1'b1; bus.pac_hit = 1'b0; bus.dots_clear = 1'b0;

    mode = MODE_RANDOM;
    for (int i = 0; i < 8000; i++) cycle();

    mode = MODE_DEATH;
    run_until_state(S_OVER, 4000, "reach_gameover");
    mode = MODE_QUIET;
    for (int i = 0; i < 60; i++) cycle();

    mode = MODE_RANDOM;
    for (int i = 0; i < 2000; i++) cycle();

    // Grind levels up to saturation, then keep clearing at 255.
    mode = MODE_CLEAR;
    n = 0;
    while (!(bus.level == 8'd255 && bus.state == 3'(S_READY)) && n < 16000) begin
      cycle();
      n++;
    end
    checks++;
    if (bus.level != 8'd255) begin
      failures++;
      $display("FAIL level_saturate: level=%0d after %0d cycles, required 255", bus.level, n);
    end
    for (int i = 0; i < 200; i++) cycle();

    run_until_state(S_CLEAR, 600, "reach_clear");
    cycle();
    cycle();
    rst_pulse = 1;
    for (int i = 0; i < 2000; i++) begin
      if (i < 1200) mode = MODE_CLEAR; else mode = MODE_RANDOM;
      cycle();
    end

    @(negedge clk);
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
